// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared width default and state encoding for the sequential divider
package seq_div_pkg;

  localparam int unsigned DEF_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_step.sv
// rtl/seq_div_step.sv - one restoring radix-2 step: shift in a dividend bit, trial-subtract, restore
module seq_div_step #(
  parameter int unsigned WIDTH = 10
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};

  // rem_i < divisor keeps shifted below 2*divisor, so diff's top bit is a true sign
  assign q_o   = ~diff[WIDTH];
  assign rem_o = q_o ? diff[WIDTH-1:0] : {rem_i[WIDTH-2:0], bit_i};

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - unsigned sequential divider, one quotient bit per cycle, ready/valid handshake
module seq_div
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;

  // acc_q shifts dividend bits out of the top while quotient bits enter at the bottom
  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (acc_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = (divisor == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          cnt_d = CNT_W'(WIDTH);
          if (divisor == '0) begin
            acc_d = '1;
            rem_d = dividend;
            dbz_d = 1'b1;
          end else begin
            acc_d = dividend;
            rem_d = '0;
            dbz_d = 1'b0;
          end
        end
      end
      ST_CALC: begin
        acc_d = {acc_q[WIDTH-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    quotient  = out_valid ? acc_q : '0;
    remainder = out_valid ? rem_q : '0;
    dbz       = out_valid & dbz_q;
  end

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - directed and random checks of seq_div against an arithmetic reference
module tb_seq_div;

  localparam int W = 10;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int checks = 0;
  int failures = 0;

  seq_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction; hold = extra DONE cycles before out_ready, noise = in_valid junk after acceptance
  task automatic do_op(input int a, input int b, input int hold, input bit noise);
    int exp_q, exp_r, exp_dbz, exp_lat, edges;
    if (b == 0) begin
      exp_q = MAXV; exp_r = a; exp_dbz = 1; exp_lat = 1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_dbz = 0; exp_lat = W + 1;
    end
    check("in_ready_before_accept", int'(in_ready), 1);
    in_valid = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(negedge clk);
    in_valid = noise;
    if (noise) begin
      dividend = W'(9);
      divisor  = W'(4);
    end
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("latency_edges", edges, exp_lat);
    check("quotient", int'(quotient), exp_q);
    check("remainder", int'(remainder), exp_r);
    check("dbz", int'(dbz), exp_dbz);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", int'(out_valid), 1);
      check("hold_quotient", int'(quotient), exp_q);
      check("hold_remainder", int'(remainder), exp_r);
      check("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("idle_after_release", int'(in_ready), 1);
    check("valid_low_after_release", int'(out_valid), 0);
    check("quotient_zero_when_invalid", int'(quotient), 0);
    check("remainder_zero_when_invalid", int'(remainder), 0);
    check("dbz_zero_when_invalid", int'(dbz), 0);
  endtask

  initial begin
    int saw_valid;
    int a, b;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_dbz", int'(dbz), 0);

    do_op(100, 7, 0, 1'b0);
    do_op(1023, 1, 0, 1'b0);
    do_op(3, 10, 0, 1'b0);
    do_op(5, 0, 0, 1'b0);
    do_op(100, 7, 5, 1'b0);
    do_op(100, 7, 2, 1'b1);
    do_op(0, 0, 1, 1'b1);
    do_op(1023, 1023, 0, 1'b0);
    do_op(0, 1, 0, 1'b0);

    // abandon a division mid-way with reset
    in_valid = 1'b1;
    dividend = W'(1000);
    divisor  = W'(3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_calc_in_ready", int'(in_ready), 1);
    check("rst_mid_calc_out_valid", int'(out_valid), 0);
    saw_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid++;
    end
    check("no_valid_after_abandon", saw_valid, 0);
    do_op(1000, 3, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, MAXV);
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 7);
        default: b = $urandom_range(1, MAXV);
      endcase
      do_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1);
  end

endmodule
